// File: rtl/uart_rx.sv
// 8N1 serial receiver with a two-flop synchronizer, mid-bit sampling, and frame-error and overrun flags.
// Defining UART_RX_PARITY_EN adds an even-parity bit between the data and stop bits, checked into parity_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_t;

  state_t               r_state, w_next;
  logic                 r_sync1, r_sync2, r_sync3;
  logic [CW-1:0]        r_cnt, w_cnt;
  logic [BW-1:0]        r_bit, w_bit;
  logic [DATA_BITS-1:0] r_shift, w_shift, r_data;
  logic                 r_valid, r_ready, r_ferr, r_ovr, r_busy;
  logic                 w_done, w_half, w_full;
`ifdef UART_RX_PARITY_EN
  logic                 r_pbit, w_pbit, r_perr;
`endif

  assign w_half = (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign w_full = (r_cnt == CW'(CLKS_PER_BIT - 1));

  // r_sync2 is the synchronized line; r_sync3 is its one-cycle delay for falling-edge detection.
  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pbit  = r_pbit;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (!r_sync2 && r_sync3) w_next = S_START;
      end
      S_START: begin
        if (w_half) begin
          w_cnt  = '0;
          w_bit  = '0;
          w_next = r_sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_cnt   = '0;
          w_shift = {r_sync2, r_shift[DATA_BITS-1:1]};
          w_bit   = r_bit + 1'b1;
          if (r_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_next = S_PARITY;
`else
            w_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_full) begin
          w_cnt  = '0;
          w_pbit = r_sync2;
          w_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_full) begin
          w_cnt  = '0;
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbit  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_valid <= w_done;
      r_busy  <= (w_next != S_IDLE);
`ifdef UART_RX_PARITY_EN
      r_pbit  <= w_pbit;
`endif
      // A completion coinciding with rd_ack keeps the new byte pending and drops any old overrun.
      if (w_done) begin
        r_data  <= r_shift;
        r_ferr  <= ~r_sync2;
        r_ready <= 1'b1;
        r_ovr   <= rd_ack ? 1'b0 : (r_ovr | r_ready);
`ifdef UART_RX_PARITY_EN
        r_perr  <= ^{r_shift, r_pbit};
`endif
      end else if (rd_ack) begin
        r_ready <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign data_ready = r_ready;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = r_busy;
  assign dbg_state  = r_state;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: deserializes 8N1 frames from a single line into a parallel byte, with error and overrun flags.
- Bit storage and state are built from D-type flops.
- Sits at the far end of a serial link, feeding a parallel consumer that acknowledges each byte.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and at least 4
DATA_BITS, 8, data bits per frame, sent LSB first

Ports:
clk  input  1  system clock; all logic on rising edge
clr  input  1  asynchronous reset, active-low
rx  input  1  serial line; idle high
rd_ack  input  1  consumer acknowledge; clears data_ready and overrun
data  output  DATA_BITS  last received byte; held until next frame completes
valid  output  1  one-cycle pulse on frame completion
data_ready  output  1  level; set on frame completion, cleared by rd_ack
frame_err  output  1  stop bit of last frame was 0; updated every frame
overrun  output  1  sticky; frame completed while data_ready was still 1
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: clr low asynchronously forces the following, regardless of clk.
  - state=IDLE, counters=0.
  - Both synchronizer flops=1.
  - data=0; valid, data_ready, frame_err, overrun, busy all 0.
  - Reset mid-frame aborts the frame with no output update.
- Synchronizer: rx passes through 2 flops to give rx_s, so rx_s lags rx by 2 edges. A third flop holds rx_s_d for edge detection.
- States: IDLE, START, DATA, STOP (PARITY is added only under the optional feature).
- IDLE:
  - On rx_s=0 with rx_s_d=1, go to START. Call this edge cycle 0.
  - A line held low never re-triggers; a 1 must be seen first.
- START:
  - Sample rx_s at cycle CLKS_PER_BIT/2.
  - 0 -> DATA, bit counter=0, baud counter=0.
  - 1 -> false start; return to IDLE with no output change.
- DATA:
  - Bit i is sampled at cycle CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT.
  - Samples shift in from the MSB side so that bit 0 ends up in data[0].
  - After bit DATA_BITS-1, go to STOP.
- STOP:
  - Sample at cycle CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT, which is 152 for the defaults.
  - frame_err <= ~rx_s.
  - Shift register -> data. The byte is delivered even when frame_err=1.
  - valid=1 for exactly one cycle. data_ready <= 1.
  - Go to IDLE at the same edge, so a back-to-back start bit half a bit later is detected.
- Overrun: set if data_ready=1 and rd_ack=0 at a frame completion.
  - The old byte is overwritten.
  - overrun stays 1 until rd_ack.
- Simultaneous rd_ack and completion in the same cycle:
  - The completion wins: data_ready stays 1.
  - overrun is not set.
  - Any earlier overrun is cleared.
- rd_ack while data_ready=0 has no effect.
- rx activity during DATA or STOP is sampled only at the mid-bit points. Glitches between sample points are ignored.
- All outputs are registered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - Parity is sampled one bit time after the last data bit, and STOP moves one bit time later.
  - Checked parity is even: XOR of data bits and parity bit must be 0.
  - Adds output parity_err (1 bit, reset 0), updated at every frame completion; the byte is still delivered.
- Undefined: no PARITY state and no parity_err port; frame is 8N1 as above.

Test Plan:
- Send 0xA5, 8N1, CLKS_PER_BIT=16 -> valid pulses 1 cycle after edge 152 (relative to the rx_s falling edge); data=0xA5, data_ready=1, frame_err=0, overrun=0.
- Low glitch of 4 clks on idle rx -> START aborts at the mid-bit check; busy returns to 0; no valid; data unchanged.
- Send 0x3C with stop bit 0 -> data=0x3C, frame_err=1; the next good frame 0x81 -> frame_err=0, and no restart occurs until rx returns high.
- Two back-to-back frames 0x11 then 0x22 without rd_ack -> second valid; data=0x22, overrun=1. Then rd_ack -> data_ready=0, overrun=0.
- Pulse clr low at the 4th data bit of a frame -> all outputs 0 immediately, state IDLE; a following frame 0x5A is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 -> parity_err=0. Send 0x07 with parity 0 -> parity_err=1, data=0x07.
